// File: rtl/cdb_arbiter_if.sv
// rtl/cdb_arbiter_if.sv - common data bus requester/broadcast interface
interface cdb_arbiter_if #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int LW = 4
);
  logic [N-1:0]    require;
  logic [N*DW-1:0] dataIn;
  logic [N*LW-1:0] labelIn;
  logic [N-1:0]    accept;
  logic            BCEN;
  logic [DW-1:0]   BCdata;
  logic [LW-1:0]   BClabel;
  logic            err;

  modport master (
    output require, dataIn, labelIn,
    input  accept, BCEN, BCdata, BClabel, err
  );

  modport slave (
    input  require, dataIn, labelIn,
    output accept, BCEN, BCdata, BClabel, err
  );
endinterface

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin CDB arbiter with registered broadcast
module cdb_arbiter #(
  parameter int N  = 4,
  parameter int DW = 32,
  parameter int LW = 4
) (
  input  logic          clk,
  input  logic          rst,
  cdb_arbiter_if.slave  bus
);
  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr;
  logic [PW-1:0] grant_idx;
  logic [PW-1:0] ptr_next;
  logic          found;
  logic [LW-1:0] win_label;
  logic [DW-1:0] win_data;
  logic          dup_tag;
  logic          zero_tag;

  // Scan from ptr with wrap-around; first set require wins.
  always_comb begin
    int idx;
    idx       = 0;
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 0; k < N; k++) begin
      idx = int'(ptr) + k;
      if (idx >= N) idx = idx - N;
      if (!found && bus.require[idx]) begin
        found     = 1'b1;
        grant_idx = PW'(idx);
      end
    end
  end

  always_comb begin
    bus.accept = '0;
    if (found && !rst) bus.accept[grant_idx] = 1'b1;
  end

  assign win_label = bus.labelIn[int'(grant_idx)*LW +: LW];
  assign win_data  = bus.dataIn[int'(grant_idx)*DW +: DW];
  assign zero_tag  = found && (win_label == '0);
  assign ptr_next  = (grant_idx == PW'(N-1)) ? '0 : grant_idx + PW'(1);

  // Two live results claiming the same producer tag is a protocol fault.
  always_comb begin
    dup_tag = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int j = i + 1; j < N; j++) begin
        if (bus.require[i] && bus.require[j] &&
            bus.labelIn[i*LW +: LW] != '0 &&
            bus.labelIn[i*LW +: LW] == bus.labelIn[j*LW +: LW])
          dup_tag = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      bus.BCEN    <= 1'b0;
      bus.BCdata  <= '0;
      bus.BClabel <= '0;
      bus.err     <= 1'b0;
    end else begin
      bus.BCEN <= found && !zero_tag;
      if (found && !zero_tag) begin
        bus.BCdata  <= win_data;
        bus.BClabel <= win_label;
      end
      if (found) ptr <= ptr_next;
      if (zero_tag || dup_tag) bus.err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - randomized self-checking bench for cdb_arbiter
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int LW = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.N(N), .DW(DW), .LW(LW)) bus ();
  cdb_arbiter #(.N(N), .DW(DW), .LW(LW)) dut (.clk(clk), .rst(rst), .bus(bus));

  int vectors = 0;
  int miscompares = 0;

  logic [N-1:0]  req_v;
  logic [DW-1:0] d_v [N];
  logic [LW-1:0] t_v [N];

  int            m_ptr;
  logic          m_bcen;
  logic [DW-1:0] m_data;
  logic [LW-1:0] m_label;
  logic          m_err;
  int            last_win;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got=%0h expected=%0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive();
    bus.require = req_v;
    for (int i = 0; i < N; i++) begin
      bus.dataIn[i*DW +: DW]  = d_v[i];
      bus.labelIn[i*LW +: LW] = t_v[i];
    end
  endtask

  task automatic check_regs();
    check("bcen", 64'(bus.BCEN), 64'(m_bcen));
    check("bcdata", 64'(bus.BCdata), 64'(m_data));
    check("bclabel", 64'(bus.BClabel), 64'(m_label));
    check("err", 64'(bus.err), 64'(m_err));
  endtask

  // One cycle: apply inputs, check the grant, clock, then check the broadcast.
  task automatic step();
    logic [N-1:0] exp_acc;
    int w;
    drive();
    #1;
    exp_acc = '0;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (m_ptr + k) % N;
      if (w < 0 && req_v[idx]) w = idx;
    end
    if (w >= 0) exp_acc[w] = 1'b1;
    check("accept", 64'(bus.accept), 64'(exp_acc));
    @(posedge clk);
    for (int i = 0; i < N; i++)
      for (int j = i + 1; j < N; j++)
        if (req_v[i] && req_v[j] && t_v[i] != 0 && t_v[i] == t_v[j]) m_err = 1'b1;
    if (w >= 0) begin
      if (t_v[w] == 0) begin
        m_err  = 1'b1;
        m_bcen = 1'b0;
      end else begin
        m_bcen  = 1'b1;
        m_data  = d_v[w];
        m_label = t_v[w];
      end
      m_ptr = (w + 1) % N;
    end else begin
      m_bcen = 1'b0;
    end
    last_win = w;
    #1;
    check_regs();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    req_v = '1;
    drive();
    #1;
    m_ptr = 0; m_bcen = 1'b0; m_data = '0; m_label = '0; m_err = 1'b0;
    check("rst_accept", 64'(bus.accept), 64'd0);
    check_regs();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic set_req(input logic [N-1:0] r);
    req_v = r;
  endtask

  initial begin
    rst = 1'b0;
    for (int i = 0; i < N; i++) begin
      d_v[i] = DW'(32'h100 + i);
      t_v[i] = LW'(i + 1);
    end
    #1;
    do_reset();

    // reset release with everyone requesting, then single request on mul
    set_req(4'b1111); step();
    set_req(4'b0000); step();
    d_v[1] = 32'h0000_0006; t_v[1] = 4'd5;
    set_req(4'b0010); step();
    check("single_data", 64'(bus.BCdata), 64'h6);
    set_req(4'b0000); step();

    // round robin over all four, tags 1..4
    do_reset();
    for (int i = 0; i < N; i++) begin
      t_v[i] = LW'(i + 1);
      d_v[i] = DW'($urandom);
    end
    set_req(4'b1111);
    for (int c = 0; c < 8; c++) step();

    // pointer wrap: grant idx3, then idx0 beats idx3, then idx3
    set_req(4'b1000); step();
    set_req(4'b1001); step();
    check("wrap_win0", 64'(last_win), 64'd0);
    step();
    check("wrap_win3", 64'(last_win), 64'd3);

    // zero-tag winner, then duplicate tags with err already set
    t_v[2] = 4'd0;
    set_req(4'b0100); step();
    t_v[2] = 4'd3;
    t_v[0] = 4'd7; t_v[1] = 4'd7;
    set_req(4'b0011); step();
    step();

    // duplicate tags alone must raise err
    do_reset();
    set_req(4'b0011); step();

    // async reset while a broadcast is live
    do_reset();
    t_v[0] = 4'd3;
    set_req(4'b0001); step();
    check("pre_rst_bcen", 64'(bus.BCEN), 64'd1);
    do_reset();
    for (int i = 0; i < N; i++) t_v[i] = LW'(i + 1);
    set_req(4'b1111); step();

    // randomized requesters honouring the hold-until-accept handshake
    set_req(4'b0000);
    for (int c = 0; c < 400; c++) begin
      if (c % 60 == 59) do_reset();
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] || last_win == i) begin
          req_v[i] = ($urandom_range(0, 1) == 1);
          d_v[i]   = DW'($urandom);
          t_v[i]   = ($urandom_range(0, 39) == 0) ? LW'(0) : LW'($urandom_range(1, 15));
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
